// File: rtl/miinst_queue.sv
// ============================================================================
// Module   : miinst_queue
// Brief    : In-order micro-instruction queue; accepts one decoded group
//            (up to MQ_N uops) per cycle and issues one uop per cycle.
//            Optional feature macro: MIQ_NOP_SQUASH_EN (drop MIOP_NOP slots).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MQ_N
`define MQ_N 4
`endif

package miinst_pkg;
   localparam logic [7:0] MIOP_NOP  = 8'h00;
   localparam logic [7:0] MIOP_JE   = 8'h01;
   localparam logic [7:0] MIOP_JNE  = 8'h02;
   localparam logic [7:0] MIOP_ADDI = 8'h03;
   localparam logic [7:0] MIOP_L    = 8'h04;

   typedef struct packed {
      logic [7:0]  op;
      logic [4:0]  dst;
      logic [4:0]  src;
      logic [31:0] imm;
      logic [63:0] pc;
   } miinst_t;
endpackage

module miinst_queue
   import miinst_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int MQ_N  = `MQ_N
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       wr_valid,
   input  miinst_t [MQ_N-1:0]         wr_miinst,
   input  logic [$clog2(MQ_N+1)-1:0]  wr_count,
   output logic                       wr_ready,
   output logic                       rd_valid,
   output miinst_t                    rd_miinst,
   input  logic                       rd_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int NW = $clog2(MQ_N + 1);
   localparam int PW = $clog2(DEPTH);

   miinst_t         r_mem [DEPTH];
   logic [PW-1:0]   r_head;
   logic [PW-1:0]   r_tail;
   logic [CW-1:0]   r_count;

   logic [NW-1:0]   w_n_raw;
   logic [NW-1:0]   w_n;
   miinst_t         w_slot [MQ_N];
   logic            w_wr_fire;
   logic            w_rd_fire;

   assign wr_ready  = (CW'(DEPTH) - r_count) >= CW'(MQ_N);
   assign rd_valid  = (r_count != '0);
   assign rd_miinst = rd_valid ? r_mem[r_head] : '0;
   assign count     = r_count;

   assign w_wr_fire = wr_valid && wr_ready;
   assign w_rd_fire = rd_valid && rd_ready;

   // Build the list of slots actually appended, packed from index 0 upward.
   always_comb begin
      int k;
      k       = 0;
      w_n_raw = (wr_count > NW'(MQ_N)) ? NW'(MQ_N) : wr_count;
      for (int i = 0; i < MQ_N; i++) begin
         w_slot[i] = '0;
      end
      for (int i = 0; i < MQ_N; i++) begin
         if (NW'(i) < w_n_raw) begin
`ifdef MIQ_NOP_SQUASH_EN
            if (wr_miinst[i].op != MIOP_NOP) begin
               w_slot[k] = wr_miinst[i];
               k         = k + 1;
            end
`else
            w_slot[k] = wr_miinst[i];
            k         = k + 1;
`endif
         end
      end
      w_n = NW'(k);
   end

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (!rst && !flush && w_wr_fire) begin
         for (int i = 0; i < MQ_N; i++) begin
            if (NW'(i) < w_n) begin
               r_mem[r_tail + PW'(i)] <= w_slot[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_rd_fire) begin
            r_head <= r_head + PW'(1);
         end
         if (w_wr_fire) begin
            r_tail <= r_tail + PW'(w_n);
         end
         r_count <= r_count + (w_wr_fire ? CW'(w_n) : CW'(0)) - (w_rd_fire ? CW'(1) : CW'(0));
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_miinst_queue.sv
// Directed plus random stimulus for miinst_queue, checked against a queue model.
`default_nettype none

module tb_miinst_queue;
   import miinst_pkg::*;

   localparam int DEPTH = 16;
   localparam int MQ_N  = 4;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int NW    = $clog2(MQ_N + 1);

   logic                clk = 1'b0;
   logic                rst;
   logic                flush;
   logic                wr_valid;
   miinst_t [MQ_N-1:0]  wr_miinst;
   logic [NW-1:0]       wr_count;
   logic                wr_ready;
   logic                rd_valid;
   miinst_t             rd_miinst;
   logic                rd_ready;
   logic [CW-1:0]       count;

   miinst_t mq[$];
   int total = 0;
   int bad   = 0;

   miinst_queue #(.DEPTH(DEPTH), .MQ_N(MQ_N)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .wr_valid (wr_valid),
      .wr_miinst(wr_miinst),
      .wr_count (wr_count),
      .wr_ready (wr_ready),
      .rd_valid (rd_valid),
      .rd_miinst(rd_miinst),
      .rd_ready (rd_ready),
      .count    (count)
   );

   always #5 clk = ~clk;

   function automatic miinst_t mk(input logic [7:0] op, input logic [63:0] pc);
      miinst_t m;
      m     = '0;
      m.op  = op;
      m.pc  = pc;
      m.imm = $urandom;
      m.dst = 5'($urandom);
      m.src = 5'($urandom);
      return m;
   endfunction

   function automatic miinst_t [MQ_N-1:0] rnd_group();
      miinst_t [MQ_N-1:0] g;
      for (int i = 0; i < MQ_N; i++) begin
         g[i] = mk(8'($urandom_range(0, 4)), {32'($urandom), 32'($urandom)});
      end
      return g;
   endfunction

   task automatic chk_outputs(input string tag);
      logic    e_valid;
      miinst_t e_mi;
      logic    e_rdy;
      e_valid = (mq.size() != 0);
      e_mi    = e_valid ? mq[0] : '0;
      e_rdy   = (DEPTH - mq.size()) >= MQ_N;
      total++;
      assert (count === CW'(mq.size())) else begin
         bad++; $error("FAIL %s count got=%0d exp=%0d", tag, count, mq.size());
      end
      total++;
      assert (rd_valid === e_valid) else begin
         bad++; $error("FAIL %s rd_valid got=%b exp=%b", tag, rd_valid, e_valid);
      end
      total++;
      assert (rd_miinst === e_mi) else begin
         bad++; $error("FAIL %s rd_miinst got=%h exp=%h", tag, rd_miinst, e_mi);
      end
      total++;
      assert (wr_ready === e_rdy) else begin
         bad++; $error("FAIL %s wr_ready got=%b exp=%b", tag, wr_ready, e_rdy);
      end
   endtask

   // One clock: drive, check pre-edge outputs, then advance the model.
   task automatic cycle(input string tag, input logic f, input logic wv,
                        input logic [NW-1:0] wc, input miinst_t [MQ_N-1:0] g,
                        input logic rr);
      bit wfire;
      bit rfire;
      int n;
      @(negedge clk);
      rst       = 1'b0;
      flush     = f;
      wr_valid  = wv;
      wr_count  = wc;
      wr_miinst = g;
      rd_ready  = rr;
      #1 chk_outputs(tag);
      wfire = wv && ((DEPTH - mq.size()) >= MQ_N);
      rfire = rr && (mq.size() != 0);
      n     = (int'(wc) > MQ_N) ? MQ_N : int'(wc);
      @(posedge clk);
      if (f) begin
         mq.delete();
      end else begin
         if (rfire) void'(mq.pop_front());
         if (wfire) begin
            for (int i = 0; i < n; i++) begin
`ifdef MIQ_NOP_SQUASH_EN
               if (g[i].op != MIOP_NOP) mq.push_back(g[i]);
`else
               mq.push_back(g[i]);
`endif
            end
         end
      end
   endtask

   task automatic idle(input string tag, input logic rr, input int cycles);
      for (int i = 0; i < cycles; i++) cycle(tag, 1'b0, 1'b0, '0, '0, rr);
   endtask

   task automatic chk_count(input string tag, input int exp);
      #2;
      total++;
      assert (count === CW'(exp)) else begin
         bad++; $error("FAIL %s count got=%0d exp=%0d", tag, count, exp);
      end
   endtask

   task automatic chk_ready(input string tag, input logic exp);
      total++;
      assert (wr_ready === exp) else begin
         bad++; $error("FAIL %s wr_ready got=%b exp=%b", tag, wr_ready, exp);
      end
   endtask

   initial begin
      miinst_t [MQ_N-1:0] g;

      rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_count = '0;
      wr_miinst = '0; rd_ready = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state and basic ordering
      g    = '0;
      g[0] = mk(MIOP_JE,   64'h100);
      g[1] = mk(MIOP_ADDI, 64'h100);
      g[2] = mk(MIOP_L,    64'h100);
      g[3] = mk(MIOP_JNE,  64'h104);
      cycle("basic_wr", 1'b0, 1'b1, 3'd3, g, 1'b0);
      chk_count("basic_cnt", 3);
      idle("basic_rd", 1'b1, 4);

      // Full and backpressure
      for (int i = 0; i < 4; i++) cycle("full_wr", 1'b0, 1'b1, 3'd4, rnd_group(), 1'b0);
      chk_count("full_cnt16", 16);
      chk_ready("full_rdy0", 1'b0);
      cycle("full_5th", 1'b0, 1'b1, 3'd4, rnd_group(), 1'b0);
      chk_count("full_5th_cnt", 16);
      idle("full_pop1", 1'b1, 1);
      chk_count("full_cnt15", 15);
      chk_ready("full_rdy_15", 1'b0);
      idle("full_pop3", 1'b1, 3);
      chk_count("full_cnt12", 12);
      chk_ready("full_rdy_12", 1'b1);
      cycle("flush_a", 1'b1, 1'b0, '0, '0, 1'b0);

      // Wrap straddle: tail reaches 14, then a group spans 14,15,0,1
      for (int i = 0; i < 3; i++) cycle("wrap_fill", 1'b0, 1'b1, 3'd4, rnd_group(), 1'b0);
      cycle("wrap_fill2", 1'b0, 1'b1, 3'd2, rnd_group(), 1'b0);
      idle("wrap_drain", 1'b1, 14);
      g = '0;
      for (int i = 0; i < MQ_N; i++) g[i] = mk(MIOP_ADDI, 64'h200 + 64'(i));
      cycle("wrap_wr", 1'b0, 1'b1, 3'd4, g, 1'b0);
      chk_count("wrap_cnt", 4);
      idle("wrap_rd", 1'b1, 5);

      // Simultaneous read and write at count 5
      cycle("sim_a", 1'b0, 1'b1, 3'd4, rnd_group(), 1'b0);
      cycle("sim_b", 1'b0, 1'b1, 3'd1, rnd_group(), 1'b0);
      chk_count("sim_cnt5", 5);
      cycle("sim_rw", 1'b0, 1'b1, 3'd2, rnd_group(), 1'b1);
      chk_count("sim_cnt6", 6);
      idle("sim_drain", 1'b1, 7);

      // Flush wins over concurrent write and read
      cycle("fl_a", 1'b0, 1'b1, 3'd4, rnd_group(), 1'b0);
      cycle("fl_b", 1'b0, 1'b1, 3'd3, rnd_group(), 1'b0);
      chk_count("fl_cnt7", 7);
      cycle("fl_go", 1'b1, 1'b1, 3'd4, rnd_group(), 1'b1);
      chk_count("fl_cnt0", 0);
      chk_ready("fl_rdy", 1'b1);
      idle("fl_after", 1'b1, 2);

      // NOP group
      g    = '0;
      g[0] = mk(MIOP_NOP,  64'h300);
      g[1] = mk(MIOP_JNE,  64'h302);
      g[2] = mk(MIOP_NOP,  64'h304);
      g[3] = mk(MIOP_ADDI, 64'h306);
      cycle("nop_wr", 1'b0, 1'b1, 3'd4, g, 1'b0);
`ifdef MIQ_NOP_SQUASH_EN
      chk_count("nop_cnt", 2);
`else
      chk_count("nop_cnt", 4);
`endif
      idle("nop_rd", 1'b1, 5);

      // Zero-count and oversize-count groups
      cycle("zero_wr", 1'b0, 1'b1, 3'd0, rnd_group(), 1'b0);
      chk_count("zero_cnt", 0);
      cycle("big_wr", 1'b0, 1'b1, 3'd7, rnd_group(), 1'b0);
      idle("big_rd", 1'b1, 5);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         cycle("rnd", ($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
               NW'($urandom_range(0, 7)), rnd_group(), $urandom_range(0, 3) != 0);
      end
      idle("rnd_drain", 1'b1, DEPTH + 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/miinst_queue.md
# miinst_queue

Micro-instruction queue between the fetch/decode phases and the execute pipeline. Accepts one decoded x86-64 instruction per cycle as a group of up to `MQ_N` micro-instructions (`miinst_t`) from the fetch phase. Buffers them in program order and issues exactly one micro-instruction per cycle over a valid/ready handshake. A flush input discards all buffered entries on control-flow redirect.

## Interface
Parameters:
- `DEPTH`, default 16: entry count; power of two; must be ≥ `MQ_N`.
- `MQ_N`, default `` `MQ_N `` from `common_params.h`: maximum micro-instructions per decoded instruction.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard all entries (branch redirect).
- `wr_valid` in 1: fetch phase presents a completed instruction group.
- `wr_miinst` in `miinst_t [MQ_N-1:0]`: the group; slot 0 is oldest.
- `wr_count` in `$clog2(MQ_N+1)`: number of meaningful slots, 0..`MQ_N`.
- `wr_ready` out 1: the queue can accept a full group this cycle.
- `rd_valid` out 1: head entry available.
- `rd_miinst` out `miinst_t`: head entry.
- `rd_ready` in 1: execute side consumes the head.
- `count` out `$clog2(DEPTH+1)`: current occupancy.

## Operation
- Storage is a circular buffer of `DEPTH` entries with `head` and `tail` pointers (mod `DEPTH`) and a `count` register.
- Write fires when `wr_valid && wr_ready`. Slots 0..`n-1` are appended at `tail`, `tail+1`, … in slot order, where `n = min(wr_count, MQ_N)`. `tail` and `count` then advance by `n`.
- Groups are atomic: a group is never partially written.
- `wr_count = 0` with a write fire is legal (ignored opcodes, e.g. Push FS). No state changes.
- Read fires when `rd_valid && rd_ready`. `head` advances by 1 and `count` decreases by 1.
- `wr_ready = (DEPTH - count) >= MQ_N`. This uses the registered `count` only; a same-cycle pop is not credited.
- `rd_valid = (count != 0)`.
- `rd_miinst` is the entry at `head` when `rd_valid = 1`, and all-zero otherwise.
- Simultaneous read and write: `count_next = count + n - 1`.
- Priority, highest first: `rst`, then `flush`, then normal read/write.
- `flush` sets `head = tail = count = 0` next cycle. Any same-cycle write or read is discarded.
- Entry contents are not cleared on reset or flush; only the pointers are.
- `wr_miinst` slots at index ≥ `n` are ignored.

## Timing
- Reset values: `rd_valid=0`, `rd_miinst=0`, `count=0`, `wr_ready=1`.
- Write-to-read latency is 1 cycle. A group written at edge k is visible on `rd_*` after edge k.
- Read is combinational from storage; the head advances at the edge where the read fires.
- Sustained throughput is 1 micro-op/cycle out and 1 group/cycle in while `wr_ready` is high.
- `wr_ready` deasserts at `count > DEPTH - MQ_N`. With `DEPTH=16`, `MQ_N=4` it deasserts at `count ≥ 13`.
- Wrap-around: pointers roll from `DEPTH-1` to 0 with no bubble. A group may straddle the wrap.
- `rst` or `flush` mid-stream: `rd_valid=0` and `wr_ready=1` in the next cycle.
- A write offered in the same cycle as flush is lost. The fetch phase must re-present it after the redirect.

## Configuration
- `MIQ_NOP_SQUASH_EN` defined:
  - Slots among 0..`n-1` whose `op == MIOP_NOP` are not enqueued.
  - The remaining slots are compacted in slot order. The effective `n` is the count of non-NOP slots.
  - The `0F 1F` NOP therefore never reaches execute.
- `MIQ_NOP_SQUASH_EN` undefined: every slot 0..`n-1` is enqueued unchanged, including NOPs.

## Test plan
(`DEPTH=16`, `MQ_N=4`)
- **Reset and basic order:** `rst` for 2 cycles, then write a group with `wr_count=3` (JE, ADDI, L; pc=0x100). Expect `rd_valid=1` the next cycle and reads in order JE, ADDI, L. Afterwards `count=0`, `rd_valid=0`, `rd_miinst=0`.
- **Full and backpressure:** 4 groups of `wr_count=4` with `rd_ready=0`. Expect `count=16` and `wr_ready=0` from `count=13` onward. A 5th `wr_valid` leaves `count` at 16. One pop is still not enough; after 4 pops (`count=12`), `wr_ready=1`.
- **Wrap straddle:** advance `head`/`tail` to 14, then write 4 entries. Expect them stored at 14, 15, 0, 1 and read back in order with no bubble.
- **Simultaneous read and write:** `count=5`, `rd_ready=1`, write `wr_count=2`. Expect `count=6` next cycle, the head advanced by 1, and the new entries at the tail.
- **Flush priority:** `count=7`, assert `flush` together with `wr_valid` (`wr_count=4`) and `rd_ready`. Expect `count=0`, `rd_valid=0`, `wr_ready=1` next cycle, and none of the written entries ever read.
- **NOP squash:** group [NOP, JNE, NOP, ADDI], `wr_count=4`. With `MIQ_NOP_SQUASH_EN` defined, expect `count=2` and reads JNE, ADDI. Without it, expect `count=4` and all four entries read in order.
